// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-slave RAM peripheral.
// Optional feature macro: RD_ADDR_AUTOINC_EN (see spi_ram_wrapper).
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [3:0] RX_BITS = 4'd10;
    localparam logic [3:0] TX_BITS = 4'd8;

endpackage

// File: rtl/spi_ram_wrapper_sp_ram.sv
// Single-port MEM_DEPTH x 8 RAM with write/read address registers, driven by
// 10-bit command words. RD_ADDR_AUTOINC_EN advances rd_addr after each data read.
module sp_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    logic [7:0]           r_mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && rx_valid && din[9:8] == CMD_WR_DATA)
            r_mem[r_wr_addr] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            if (rx_valid) begin
                case (din[9:8])
                    CMD_WR_ADDR: r_wr_addr <= din[ADDR_SIZE-1:0];
                    CMD_RD_ADDR: r_rd_addr <= din[ADDR_SIZE-1:0];
                    CMD_RD_DATA: begin
                        r_dout     <= r_mem[r_rd_addr];
                        r_tx_valid <= 1'b1;
`ifdef RD_ADDR_AUTOINC_EN
                        r_rd_addr  <= r_rd_addr + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI slave front end (CHK + 10-bit frames, MSB first) over a byte-wide RAM.
// Macro RD_ADDR_AUTOINC_EN keeps rd_addr_seen set so reads stream successive bytes.
module spi_ram_wrapper
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_tx_cnt;
    logic [9:0] r_rx;
    logic       r_rx_valid;
    logic       r_rd_addr_seen;
    logic       r_miso;
    logic [7:0] r_tx_shift;
    logic       w_tx_valid;
    logic [7:0] w_tx_data;
    logic       w_rx_phase;

    assign w_rx_phase = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= 4'd0;
            r_tx_cnt       <= 4'd0;
            r_rx           <= 10'd0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_miso         <= 1'b0;
            r_tx_shift     <= 8'h00;
        end else begin
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b0;
            if (r_rx_valid && r_rx[9:8] == CMD_RD_ADDR)
                r_rd_addr_seen <= 1'b1;
            if (SS_n) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: r_state <= CHK_CMD;
                    CHK_CMD: begin
                        r_cnt    <= 4'd0;
                        r_tx_cnt <= 4'd0;
                        if (!MOSI)
                            r_state <= WRITE;
                        else if (r_rd_addr_seen)
                            r_state <= READ_DATA;
                        else
                            r_state <= READ_ADD;
                    end
                    default: ;
                endcase
                // Receive exactly RX_BITS bits, then hold; extra cycles are ignored.
                if (w_rx_phase && r_cnt != RX_BITS) begin
                    r_rx  <= {r_rx[8:0], MOSI};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == RX_BITS - 4'd1)
                        r_rx_valid <= 1'b1;
                end
                if (r_state == READ_DATA && r_cnt == RX_BITS) begin
                    if (r_tx_cnt == 4'd0) begin
                        if (w_tx_valid) begin
                            r_miso     <= w_tx_data[7];
                            r_tx_shift <= {w_tx_data[6:0], 1'b0};
                            r_tx_cnt   <= 4'd1;
                        end
                    end else if (r_tx_cnt != TX_BITS) begin
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        r_tx_cnt   <= r_tx_cnt + 4'd1;
`ifndef RD_ADDR_AUTOINC_EN
                        if (r_tx_cnt == TX_BITS - 4'd1)
                            r_rd_addr_seen <= 1'b0;
`endif
                    end
                end
            end
        end
    end

    assign MISO = r_miso;

    sp_ram #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .din     (r_rx),
        .rx_valid(r_rx_valid),
        .dout    (w_tx_data),
        .tx_valid(w_tx_valid)
    );

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Directed frame-table bench for spi_ram_wrapper (default build, RD_ADDR_AUTOINC_EN undefined).
// Each frame: one IDLE cycle, CHK bit, 10 rx bits, then filler up to 20 cycles.
module tb_spi_ram_wrapper;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic MOSI;
    logic SS_n;
    logic MISO;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       chk;
        logic [9:0] word;
        state_t     exp_st;
        logic [7:0] exp_miso;
    } frame_t;

    frame_t vecs[14];

    spi_ram_wrapper dut (
        .clk (clk),
        .rst (rst),
        .MOSI(MOSI),
        .SS_n(SS_n),
        .MISO(MISO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Assumes SS_n high / IDLE on entry; leaves SS_n low on exit.
    task automatic do_frame(input logic chk, input logic [9:0] word, input int ncyc,
                            output state_t st1, output int rxv_cnt, output int rxv_k,
                            output logic [9:0] rx_word, output logic [7:0] miso_byte,
                            output int stray);
        st1 = IDLE; rxv_cnt = 0; rxv_k = 0; rx_word = '0; miso_byte = '0; stray = 0;
        SS_n = 1'b0;
        MOSI = 1'b0;
        step();
        for (int k = 1; k <= ncyc; k++) begin
            if (k == 1)
                MOSI = chk;
            else if (k <= 11)
                MOSI = word[11-k];
            else
                MOSI = 1'($urandom_range(0, 1));
            step();
            if (k == 1)
                st1 = dut.r_state;
            if (dut.r_rx_valid) begin
                rxv_cnt++;
                rxv_k   = k;
                rx_word = dut.r_rx;
            end
            if (k >= 13 && k <= 20)
                miso_byte[20-k] = MISO;
            else if (MISO !== 1'b0)
                stray++;
        end
    endtask

    task automatic run_vec(input int idx, input frame_t v);
        state_t     st1;
        int         rxv_cnt, rxv_k, stray;
        logic [9:0] rx_word;
        logic [7:0] miso_byte;
        do_frame(v.chk, v.word, 20, st1, rxv_cnt, rxv_k, rx_word, miso_byte, stray);
        check($sformatf("v%0d_state", idx), st1, v.exp_st);
        check($sformatf("v%0d_rxv_count", idx), rxv_cnt, 1);
        check($sformatf("v%0d_rxv_cycle", idx), rxv_k, 11);
        check($sformatf("v%0d_rx_word", idx), rx_word, v.word);
        check($sformatf("v%0d_miso_byte", idx), miso_byte, v.exp_miso);
        check($sformatf("v%0d_miso_stray", idx), stray, 0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
        check($sformatf("v%0d_idle_after", idx), dut.r_state, IDLE);
        check($sformatf("v%0d_miso_after", idx), MISO, 1'b0);
    endtask

    initial begin
        state_t     st1;
        int         rxv_cnt, rxv_k, stray;
        logic [9:0] rx_word;
        logic [7:0] miso_byte;

        vecs[0]  = '{1'b0, 10'b00_11001100, WRITE,     8'h00};
        vecs[1]  = '{1'b0, 10'b01_11001100, WRITE,     8'h00};
        vecs[2]  = '{1'b1, 10'b10_11001100, READ_ADD,  8'h00};
        vecs[3]  = '{1'b1, 10'b11_11111111, READ_DATA, 8'hCC};
        vecs[4]  = '{1'b0, 10'b00_00000101, WRITE,     8'h00};
        vecs[5]  = '{1'b0, 10'b01_10100101, WRITE,     8'h00};
        vecs[6]  = '{1'b0, 10'b00_11111111, WRITE,     8'h00};
        vecs[7]  = '{1'b0, 10'b01_00111100, WRITE,     8'h00};
        vecs[8]  = '{1'b1, 10'b10_00000101, READ_ADD,  8'h00};
        vecs[9]  = '{1'b1, 10'b11_00000000, READ_DATA, 8'hA5};
        vecs[10] = '{1'b1, 10'b10_11111111, READ_ADD,  8'h00};
        vecs[11] = '{1'b1, 10'b11_01011010, READ_DATA, 8'h3C};
        vecs[12] = '{1'b1, 10'b10_11001100, READ_ADD,  8'h00};
        vecs[13] = '{1'b1, 10'b11_00000000, READ_DATA, 8'hCC};

        // Reset, including with SS_n asserted.
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        step(); step();
        check("rst_miso", MISO, 1'b0);
        check("rst_state", dut.r_state, IDLE);
        check("rst_rx_valid", dut.r_rx_valid, 1'b0);
        check("rst_rd_addr_seen", dut.r_rd_addr_seen, 1'b0);
        SS_n = 1'b0;
        step();
        check("rst_holds_idle", dut.r_state, IDLE);
        rst = 1'b0; SS_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++)
            run_vec(i, vecs[i]);

        // Abort a write-data frame after 5 payload bits.
        run_vec(100, '{1'b0, 10'b00_11001100, WRITE, 8'h00});
        do_frame(1'b0, 10'b01_00000000, 6, st1, rxv_cnt, rxv_k, rx_word, miso_byte, stray);
        check("abort_state", st1, WRITE);
        SS_n = 1'b1; MOSI = 1'b0;
        step();
        check("abort_idle", dut.r_state, IDLE);
        rxv_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (dut.r_rx_valid) rxv_cnt++;
            step();
        end
        check("abort_no_rx_valid", rxv_cnt, 0);
        run_vec(101, '{1'b1, 10'b10_11001100, READ_ADD,  8'h00});
        run_vec(102, '{1'b1, 10'b11_00000000, READ_DATA, 8'hCC});

        // Reset in the middle of a read-data shift-out.
        run_vec(103, '{1'b1, 10'b10_11001100, READ_ADD, 8'h00});
        do_frame(1'b1, 10'b11_00000000, 16, st1, rxv_cnt, rxv_k, rx_word, miso_byte, stray);
        check("midrst_state", st1, READ_DATA);
        check("midrst_partial_miso", miso_byte[7:4], 4'hC);
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
        step();
        check("midrst_miso", MISO, 1'b0);
        check("midrst_idle", dut.r_state, IDLE);
        check("midrst_seen_cleared", dut.r_rd_addr_seen, 1'b0);
        rst = 1'b0;
        step();
        run_vec(104, '{1'b1, 10'b11_00000000, READ_ADD,  8'h00});
        run_vec(105, '{1'b0, 10'b01_01011010, WRITE,     8'h00});
        run_vec(106, '{1'b1, 10'b10_00000000, READ_ADD,  8'h00});
        run_vec(107, '{1'b1, 10'b11_00000000, READ_DATA, 8'h5A});
        run_vec(108, '{1'b1, 10'b10_11001100, READ_ADD,  8'h00});
        run_vec(109, '{1'b1, 10'b11_11111111, READ_DATA, 8'hCC});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
